// File: rtl/usr_pkg.sv
// usr_pkg: shared encodings for the universal shift register.
// Op codes, burst FSM states and barrel shifter modes.
package usr_pkg;

  localparam logic [2:0] USR_HOLD  = 3'b000;
  localparam logic [2:0] USR_SHR   = 3'b001;
  localparam logic [2:0] USR_SHL   = 3'b010;
  localparam logic [2:0] USR_LOAD  = 3'b011;
  localparam logic [2:0] USR_ROR   = 3'b100;
  localparam logic [2:0] USR_ROL   = 3'b101;
  localparam logic [2:0] USR_ASR   = 3'b110;
  localparam logic [2:0] USR_BURST = 3'b111;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam logic [1:0] BM_LOG = 2'd0;
  localparam logic [1:0] BM_ROT = 2'd1;
  localparam logic [1:0] BM_ARI = 2'd2;

endpackage

// File: rtl/usr_barrel.sv
// usr_barrel: combinational shifter/rotator.
// dir=0 shifts right, dir=1 shifts left.
module usr_barrel
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] res
);

  logic [2*WIDTH-1:0] ext;
  logic [2*WIDTH-1:0] sh;
  logic [AMT_W-1:0]   ramt;
  logic               fbit;

  // Double-width window: shifted-out bits fall off, fill or wrap bits enter.
  always_comb begin
    ext  = '0;
    sh   = '0;
    res  = '0;
    ramt = amt;
    fbit = (mode == BM_ARI) ? data[WIDTH-1] : fill;
    if (mode == BM_ROT) begin
      ramt = AMT_W'(amt % WIDTH);
      ext  = {data, data};
    end else if (dir) begin
      ext = {data, {WIDTH{fbit}}};
    end else begin
      ext = {{WIDTH{fbit}}, data};
    end
    if (dir) begin
      sh  = ext << ramt;
      res = sh[2*WIDTH-1:WIDTH];
    end else begin
      sh  = ext >> ramt;
      res = sh[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/usr_param.sv
// usr_param: parametrised universal shift register
// with multi-bit shifts/rotates and a self-timed burst serialiser.
module usr_param
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic             sinr,
  input  logic             sinl,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] pout,
  output logic             soutr,
  output logic             soutl,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] pout_q, pout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic             done_q, done_d;

  logic             bar_dir;
  logic [1:0]       bar_mode;
  logic             bar_fill;
  logic [WIDTH-1:0] bar_res;

  usr_barrel #(.WIDTH(WIDTH)) u_barrel (
    .data (pout_q),
    .amt  (amt),
    .dir  (bar_dir),
    .mode (bar_mode),
    .fill (bar_fill),
    .res  (bar_res)
  );

  // Barrel control decoded from the op code.
  always_comb begin
    bar_dir  = 1'b0;
    bar_mode = BM_LOG;
    bar_fill = sinr;
    unique case (op)
      USR_SHL: begin
        bar_dir  = 1'b1;
        bar_fill = sinl;
      end
      USR_ROR: bar_mode = BM_ROT;
      USR_ROL: begin
        bar_dir  = 1'b1;
        bar_mode = BM_ROT;
      end
      USR_ASR: bar_mode = BM_ARI;
      default: ;
    endcase
  end

  // Next-state: op execution when idle, serialising when in a burst.
  // On the final burst edge a held 111 chains straight into a new burst.
  always_comb begin
    pout_d  = pout_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        unique case (op)
          USR_HOLD: ;
          USR_LOAD: pout_d = inp;
          USR_BURST: begin
            state_d = S_BURST;
            cnt_d   = CW'(WIDTH);
          end
          default: pout_d = bar_res;
        endcase
      end
      S_BURST: begin
        pout_d = {sinr, pout_q[WIDTH-1:1]};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          done_d = 1'b1;
          if (op == USR_BURST) begin
            cnt_d = CW'(WIDTH);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pout_q  <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      pout_q  <= pout_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign pout  = pout_q;
  assign soutr = pout_q[0];
  assign soutl = pout_q[WIDTH-1];
  assign busy  = (state_q == S_BURST);
  assign done  = done_q;

endmodule

// File: tb/tb_usr_param.sv
// tb_usr_param: random + directed bench for usr_param (WIDTH=8)
// against a bit-level behavioural model.
module tb_usr_param;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [2:0] op = 3'd0;
  logic [2:0] amt = 3'd0;
  logic       sinr = 1'b0;
  logic       sinl = 1'b0;
  logic [7:0] inp = 8'd0;
  logic [7:0] pout;
  logic       soutr, soutl, busy, done;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  usr_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .op    (op),
    .amt   (amt),
    .sinr  (sinr),
    .sinl  (sinl),
    .inp   (inp),
    .pout  (pout),
    .soutr (soutr),
    .soutl (soutl),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Model: register value, remaining burst bits, done flag.
  logic [7:0] m_pout = 8'd0;
  int         m_left = 0;
  bit         m_done = 1'b0;

  logic [7:0] mn;
  int         ml, a;
  bit         md;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_pout <= 8'd0;
      m_left <= 0;
      m_done <= 1'b0;
    end else begin
      mn = m_pout;
      ml = m_left;
      md = 1'b0;
      a  = int'(amt);
      if (m_left > 0) begin
        mn = {sinr, m_pout[7:1]};
        ml = m_left - 1;
        if (ml == 0) begin
          md = 1'b1;
          if (op == 3'b111) ml = W;
        end
      end else begin
        case (op)
          3'b001: for (int i = 0; i < W; i++)
            mn[i] = (i + a < W) ? m_pout[i + a] : sinr;
          3'b010: for (int i = 0; i < W; i++)
            mn[i] = (i >= a) ? m_pout[i - a] : sinl;
          3'b011: mn = inp;
          3'b100: for (int i = 0; i < W; i++)
            mn[i] = m_pout[(i + a) % W];
          3'b101: for (int i = 0; i < W; i++)
            mn[i] = m_pout[(i - a + W) % W];
          3'b110: for (int i = 0; i < W; i++)
            mn[i] = (i + a < W) ? m_pout[i + a] : m_pout[7];
          3'b111: ml = W;
          default: ;
        endcase
      end
      m_pout <= mn;
      m_left <= ml;
      m_done <= md;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_pout", int'(pout), int'(m_pout));
      check("cyc_soutr", int'(soutr), int'(m_pout[0]));
      check("cyc_soutl", int'(soutl), int'(m_pout[7]));
      check("cyc_busy", int'(busy), int'(m_left > 0));
      check("cyc_done", int'(done), int'(m_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    op  = 3'b011;
    inp = v;
    tick();
  endtask

  logic [7:0] bexp;
  int nb_low, nb_done;

  initial begin
    #3;
    check("rst_pout", int'(pout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_soutr", int'(soutr), 0);
    chk_en = 1'b1;
    tick();
    tick();
    clr_n = 1'b1;

    load(8'hF5);
    check("load", int'(pout), 'hF5);
    check("load_soutr", int'(soutr), 1);
    check("load_soutl", int'(soutl), 1);

    op = 3'b001; amt = 3'd1; sinr = 1'b0; tick();
    check("shr1", int'(pout), 'h7A);
    op = 3'b010; amt = 3'd2; sinl = 1'b1; tick();
    check("shl2", int'(pout), 'hEB);
    op = 3'b001; amt = 3'd0; tick();
    check("shr0", int'(pout), 'hEB);

    load(8'hF5);
    op = 3'b101; amt = 3'd3; tick();
    check("rol3", int'(pout), 'hAF);
    load(8'hF5);
    op = 3'b110; amt = 3'd2; tick();
    check("asr2_neg", int'(pout), 'hFD);
    load(8'h75);
    op = 3'b110; amt = 3'd3; tick();
    check("asr3_pos", int'(pout), 'h0E);

    // Single burst; a load request during busy must be ignored.
    load(8'h66);
    bexp = 8'h66;
    op = 3'b111; sinr = 1'b1; tick();
    op = 3'b011; inp = 8'h00;
    for (int k = 0; k < W; k++) begin
      check("burst_busy", int'(busy), 1);
      check("burst_soutr", int'(soutr), int'(bexp[k]));
      check("burst_nodone", int'(done), 0);
      tick();
    end
    op = 3'b000;
    check("burst_end_busy", int'(busy), 0);
    check("burst_end_done", int'(done), 1);
    check("burst_end_pout", int'(pout), 'hFF);
    tick();
    check("done_pulse", int'(done), 0);
    check("burst_hold", int'(pout), 'hFF);

    // Back-to-back bursts with op held at 111.
    load(8'hA5);
    op = 3'b111; sinr = 1'b0; tick();
    nb_low = 0;
    nb_done = 0;
    for (int i = 1; i <= 2 * W; i++) begin
      tick();
      if (!busy) nb_low++;
      if (done) begin
        nb_done++;
        check("b2b_done_at", i % W, 0);
      end
    end
    op = 3'b000;
    check("b2b_gap", nb_low, 0);
    check("b2b_ndone", nb_done, 2);
    for (int i = 0; i < 3 * W && busy; i++) tick();
    check("b2b_drain", int'(busy), 0);
    check("b2b_pout", int'(pout), 0);

    // Asynchronous reset at busy cycle 3.
    load(8'h66);
    op = 3'b111; tick();
    op = 3'b000;
    tick(); tick(); tick();
    check("mid_busy_pre", int'(busy), 1);
    #2 clr_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_pout", int'(pout), 0);
    check("abort_done", int'(done), 0);
    tick();
    check("abort_nodone", int'(done), 0);
    tick();
    clr_n = 1'b1;
    load(8'h3C);
    check("post_rst_load", int'(pout), 'h3C);

    // Randomised traffic checked cycle-by-cycle by the model.
    for (int n = 0; n < 600; n++) begin
      op   = 3'($urandom_range(0, 7));
      if (op == 3'b111 && $urandom_range(0, 3) != 0)
        op = 3'($urandom_range(0, 6));
      amt  = 3'($urandom);
      sinr = 1'($urandom);
      sinl = 1'($urandom);
      inp  = 8'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #2 clr_n = 1'b0;
        #1 check("rnd_rst_pout", int'(pout), 0);
        tick();
        clr_n = 1'b1;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
